// File: rtl/out_bram_drain.sv
// rtl/out_bram_drain.sv - packs 128-bit tree results into 256-bit BRAM words and drains a frame over valid/ready
module out_bram_drain #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic [127:0] res_data,
    input  logic         res_vld,
    output logic [255:0] out_data,
    output logic         out_vld,
    input  logic         out_ready,
    output logic         done,
    output logic         overflow,
    output logic [1:0]   state
);
    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [255:0]          r_mem [DEPTH];
    logic [127:0]          r_low;
    logic                  r_half;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ADDR_WIDTH-1:0] r_xfer_cnt;
    logic                  r_rd_done;
    logic                  r_rd_vld;
    logic [255:0]          r_rdata;
    logic [255:0]          r_fifo [2];
    logic                  r_fifo_wp;
    logic                  r_fifo_rp;
    logic [1:0]            r_fifo_cnt;
    logic [255:0]          r_out_data;
    logic                  r_out_vld;
    logic                  r_done;
    logic                  r_overflow;

    logic [ADDR_WIDTH-1:0] w_last;
    logic                  w_wr_pair;
    logic                  w_wr_last;
    logic                  w_rd_en;
    logic                  w_xfer;
    logic                  w_last_xfer;
    logic                  w_out_free;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_push;

    assign w_last      = (mode == 2'd0) ? ADDR_WIDTH'(255) : ADDR_WIDTH'(1023);
    assign w_wr_pair   = (r_state == S_COLLECT) && res_vld && r_half;
    assign w_wr_last   = w_wr_pair && (r_waddr == w_last);
    assign w_xfer      = (r_state == S_DRAIN) && r_out_vld && out_ready;
    assign w_last_xfer = w_xfer && (r_xfer_cnt == w_last);
    assign w_out_free  = !r_out_vld || w_xfer;
    assign w_pop       = w_out_free && (r_fifo_cnt != 2'd0);
    // FIFO is bypassed only when empty so word order is preserved
    assign w_bypass    = w_out_free && (r_fifo_cnt == 2'd0) && r_rd_vld;
    assign w_push      = r_rd_vld && !w_bypass;
    // Credit counts the read already in the BRAM output stage
    assign w_rd_en     = (r_state == S_DRAIN) && !r_rd_done &&
                         ((r_fifo_cnt + 2'(r_rd_vld)) < 2'd2);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_COLLECT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_wr_last)   w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_last_xfer) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_DONE;
            default:   w_state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half  <= 1'b0;
            r_low   <= '0;
            r_waddr <= '0;
        end else if (r_state == S_COLLECT && res_vld) begin
            if (!r_half) begin
                r_low  <= res_data;
                r_half <= 1'b1;
            end else begin
                r_half  <= 1'b0;
                r_waddr <= w_wr_last ? '0 : r_waddr + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_pair) r_mem[r_waddr] <= {res_data, r_low};
        if (w_rd_en)   r_rdata <= r_mem[r_raddr];
        if (w_push)    r_fifo[r_fifo_wp] <= r_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raddr   <= '0;
            r_rd_done <= 1'b0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                if (r_raddr == w_last) r_rd_done <= 1'b1;
                else                   r_raddr   <= r_raddr + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_wp  <= 1'b0;
            r_fifo_rp  <= 1'b0;
            r_fifo_cnt <= 2'd0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_push) r_fifo_wp <= !r_fifo_wp;
            if (w_pop)  r_fifo_rp <= !r_fifo_rp;
            r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
            if (w_xfer) r_xfer_cnt <= r_xfer_cnt + ADDR_WIDTH'(1);
            if (w_out_free) begin
                r_out_vld <= w_pop || w_bypass;
                if (w_pop)         r_out_data <= r_fifo[r_fifo_rp];
                else if (w_bypass) r_out_data <= r_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_last_xfer) r_done <= 1'b1;
            if (res_vld && r_state != S_COLLECT) r_overflow <= 1'b1;
        end
    end

    assign out_data = r_out_data;
    assign out_vld  = r_out_vld;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign state    = r_state;
endmodule

// File: tb/tb_out_bram_drain.sv
// tb/tb_out_bram_drain.sv - directed scoreboard bench for out_bram_drain
module tb_out_bram_drain;
    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic [127:0] res_data;
    logic         res_vld;
    logic [255:0] out_data;
    logic         out_vld;
    logic         out_ready;
    logic         done;
    logic         overflow;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;
    logic [255:0] sb[$];
    logic [127:0] low_tb;
    bit           half_tb;
    bit           stall_prev;
    logic [255:0] prev_data;

    out_bram_drain #(.DEPTH(1024), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .mode(mode), .res_data(res_data), .res_vld(res_vld),
        .out_data(out_data), .out_vld(out_vld), .out_ready(out_ready),
        .done(done), .overflow(overflow), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; drives one cycle and consumes a transfer if one happens.
    task automatic cyc(input bit v, input logic [127:0] d, input bit rdy);
        if (stall_prev) begin
            chk("stall_vld", 256'(out_vld), 256'(1));
            chk("stall_data", out_data, prev_data);
        end
        res_vld   = v;
        res_data  = d;
        out_ready = rdy;
        if (out_vld && rdy) begin
            if (sb.size() == 0) chk("extra_word", out_data, 256'hx);
            else                chk("word", out_data, sb.pop_front());
        end
        stall_prev = out_vld && !rdy;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        res_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; res_vld = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        half_tb = 0;
        stall_prev = 0;
    endtask

    task automatic send(input int n, input bit gaps, input bit seq);
        logic [127:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, '0, 1'b0);
            d = seq ? 128'(i) : {$urandom, $urandom, $urandom, $urandom};
            if (half_tb) sb.push_back({d, low_tb});
            else         low_tb = d;
            half_tb = !half_tb;
            cyc(1'b1, d, 1'b0);
        end
    endtask

    task automatic drain(input int pct, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc(1'b0, '0, $urandom_range(0, 99) < pct);
            n++;
        end
        chk("drain_timeout", 256'(n < budget), 256'(1));
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; res_data = '0; res_vld = 1'b0; out_ready = 1'b0;
        half_tb = 0; stall_prev = 0; low_tb = '0; prev_data = '0;
        do_reset();
        chk("rst_state", 256'(state), 256'(0));
        chk("rst_vld", 256'(out_vld), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_ovf", 256'(overflow), 256'(0));
        chk("rst_data", out_data, 256'(0));

        // Mode 0, back-to-back strobes, sequential data, full-rate drain
        mode = 2'd0;
        send(512, 1'b0, 1'b1);
        chk("m0_state_drain", 256'(state), 256'(1));
        cyc(1'b0, '0, 1'b1);
        chk("m0_vld_t2", 256'(out_vld), 256'(0));
        cyc(1'b0, '0, 1'b1);
        chk("m0_vld_t3", 256'(out_vld), 256'(1));
        chk("m0_word0", out_data, {128'(1), 128'(0)});
        for (int k = 0; k < 256; k++) begin
            chk("m0_consec_vld", 256'(out_vld), 256'(1));
            cyc(1'b0, '0, 1'b1);
        end
        chk("m0_done", 256'(done), 256'(1));
        chk("m0_state_done", 256'(state), 256'(2));
        chk("m0_vld_off", 256'(out_vld), 256'(0));
        chk("m0_sb_empty", 256'(sb.size()), 256'(0));
        cyc(1'b0, '0, 1'b1);
        chk("m0_done_sticky", 256'(done), 256'(1));

        // Mode 3, random gaps, 30% ready
        do_reset();
        mode = 2'd3;
        send(2048, 1'b1, 1'b0);
        drain(30, 10000);
        chk("m3_done", 256'(done), 256'(1));
        chk("m3_vld_off", 256'(out_vld), 256'(0));

        // Long stall with an overflow pulse during DRAIN
        do_reset();
        mode = 2'd0;
        send(512, 1'b0, 1'b0);
        for (int i = 0; i < 5 && !out_vld; i++) cyc(1'b0, '0, 1'b0);
        chk("stall_vld_up", 256'(out_vld), 256'(1));
        for (int i = 0; i < 50; i++) begin
            chk("hold_word0", out_data, sb[0]);
            if (i == 10) chk("ovf_before", 256'(overflow), 256'(0));
            cyc(i == 10, 128'hdead, 1'b0);
            if (i == 10) chk("ovf_set", 256'(overflow), 256'(1));
        end
        drain(100, 2000);
        chk("ovf_done", 256'(done), 256'(1));
        chk("ovf_sticky", 256'(overflow), 256'(1));

        // Reset in the middle of a drain, then a fresh mode-1 frame
        do_reset();
        mode = 2'd0;
        send(512, 1'b0, 1'b0);
        cyc(1'b1, 128'hbeef, 1'b1);
        for (int n = 0; sb.size() > 156 && n < 1000; n++) cyc(1'b0, '0, 1'b1);
        chk("mid_ovf", 256'(overflow), 256'(1));
        chk("mid_count", 256'(sb.size()), 256'(156));
        do_reset();
        chk("mid_rst_state", 256'(state), 256'(0));
        chk("mid_rst_vld", 256'(out_vld), 256'(0));
        chk("mid_rst_done", 256'(done), 256'(0));
        chk("mid_rst_ovf", 256'(overflow), 256'(0));
        mode = 2'd1;
        send(2048, 1'b1, 1'b0);
        drain(50, 8000);
        chk("m1_done", 256'(done), 256'(1));

        // Odd strobe count stays in COLLECT until the pair completes
        do_reset();
        mode = 2'd0;
        send(511, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b1);
        chk("odd_state", 256'(state), 256'(0));
        chk("odd_half", 256'(dut.r_half), 256'(1));
        chk("odd_vld", 256'(out_vld), 256'(0));
        send(1, 1'b0, 1'b0);
        chk("odd_drain", 256'(state), 256'(1));
        drain(100, 2000);
        chk("odd_done", 256'(done), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
